// File: rtl/fp32_accumulator.sv
// fp32_accumulator: sums a valid/ready stream of FP32 beats per packet through one fp32_adder feedback loop.
// fp32_adder: combinational FP32 add, round-to-nearest-even, with fixed NaN/inf/zero shortcuts.
module fp32_adder (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] o
);
    logic        a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, swap, up;
    logic [31:0] x, y, r;
    logic [7:0]  ex, ey, d;
    logic [4:0]  sh, lz;
    logic [26:0] mx, my, ms, n;
    logic [27:0] s;
    logic [9:0]  e, amt, ef;
    logic [24:0] mr;
    assign a_nan  = (&a[30:23]) && (|a[22:0]);
    assign b_nan  = (&b[30:23]) && (|b[22:0]);
    assign a_inf  = (&a[30:23]) && !(|a[22:0]);
    assign b_inf  = (&b[30:23]) && !(|b[22:0]);
    assign a_zero = ~|a[30:0];
    assign b_zero = ~|b[30:0];
    assign swap   = b[30:0] > a[30:0];
    assign x      = swap ? b : a;
    assign y      = swap ? a : b;
    assign ex     = (x[30:23] == 8'd0) ? 8'd1 : x[30:23];
    assign ey     = (y[30:23] == 8'd0) ? 8'd1 : y[30:23];
    assign mx     = {|x[30:23], x[22:0], 3'b000};
    assign my     = {|y[30:23], y[22:0], 3'b000};
    assign d      = ex - ey;
    assign sh     = (d > 8'd27) ? 5'd27 : d[4:0];
    // Bits shifted out of the smaller operand collapse into a sticky LSB.
    assign ms     = (my >> sh) | {26'd0, |(my & ~({27{1'b1}} << sh))};
    assign s      = (x[31] == y[31]) ? {1'b0, mx} + {1'b0, ms} : {1'b0, mx} - {1'b0, ms};
    always_comb begin
        lz = 5'd27;
        for (int i = 0; i < 27; i++) if (s[i]) lz = 5'(26 - i);
        // Normalisation stops at exponent 1 so tiny results come out subnormal.
        amt = ({5'd0, lz} < ({2'd0, ex} - 10'd1)) ? {5'd0, lz} : {2'd0, ex} - 10'd1;
        e   = s[27] ? {2'd0, ex} + 10'd1 : {2'd0, ex} - amt;
        n   = s[27] ? {s[27:2], s[1] | s[0]} : s[26:0] << amt;
        up  = n[2] & (n[1] | n[0] | n[3]);
        mr  = {1'b0, n[26:3]} + {24'd0, up};
        ef  = mr[24] ? e + 10'd1 : (mr[23] ? e : 10'd0);
        r   = (s == 28'd0) ? 32'h0000_0000 :
              (ef >= 10'd255) ? {x[31], 8'hFF, 23'd0} : {x[31], ef[7:0], mr[22:0]};
        o   = a_nan ? a :
              b_nan ? b :
              (a_inf && b_inf && (a[31] ^ b[31])) ? 32'h7FFF_FFFF :
              a_inf ? a :
              b_inf ? b :
              b_zero ? a :
              a_zero ? b : r;
    end
endmodule

module fp32_accumulator #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_data,
    output logic [CNT_W-1:0] out_count
);
    typedef enum logic {ACCUM, DONE} state_t;
    state_t           state;
    logic [31:0]      acc, sum;
    logic [CNT_W-1:0] cnt, cnt_inc;
    assign in_ready = (state == ACCUM);
    assign cnt_inc  = (&cnt) ? cnt : cnt + 1'b1;
    fp32_adder u_add (.a(acc), .b(in_data), .o(sum));
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ACCUM;
            acc       <= '0;
            cnt       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_count <= '0;
        end else if (state == ACCUM) begin
            if (in_valid && in_last) begin
                out_data  <= sum;
                out_count <= cnt_inc;
                out_valid <= 1'b1;
                acc       <= '0;
                cnt       <= '0;
                state     <= DONE;
            end else if (in_valid) begin
                acc <= sum;
                cnt <= cnt_inc;
            end
        end else if (out_ready) begin
            out_valid <= 1'b0;
            state     <= ACCUM;
        end
    end
endmodule

// File: tb/tb_fp32_accumulator.sv
// tb_fp32_accumulator: directed packets with hand-computed FP32 sums, main and CNT_W=2 instances in lockstep.
module tb_fp32_accumulator;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_data = 32'd0;
    logic        in_last = 1'b0;
    logic        out_ready = 1'b0;
    logic        in_ready, out_valid, sat_in_ready, sat_out_valid;
    logic [31:0] out_data, sat_out_data;
    logic [15:0] out_count;
    logic [1:0]  sat_out_count;
    int          n_cmp = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    fp32_accumulator #(.CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_last(in_last), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_count(out_count)
    );

    fp32_accumulator #(.CNT_W(2)) u_sat (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(sat_in_ready),
        .in_data(in_data), .in_last(in_last), .out_valid(sat_out_valid),
        .out_ready(out_ready), .out_data(sat_out_data), .out_count(sat_out_count)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic beat(input logic [31:0] d, input logic l);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = 32'hDEAD_BEEF;
        in_last  = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic result(input string tag, input logic [31:0] d, input logic [31:0] c);
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_data"}, out_data, d);
        check({tag, "_count"}, 32'(out_count), c);
        check({tag, "_in_ready"}, 32'(in_ready), 32'd0);
    endtask

    task automatic take();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("take_valid_low", 32'(out_valid), 32'd0);
        check("take_in_ready", 32'(in_ready), 32'd1);
    endtask

    initial begin
        #2;
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_data", out_data, 32'd0);
        check("rst_count", 32'(out_count), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        beat(32'h3F80_0000, 1'b0);
        beat(32'h4000_0000, 1'b0);
        check("sum3_not_yet", 32'(out_valid), 32'd0);
        beat(32'h4040_0000, 1'b1);
        result("sum3", 32'h40C0_0000, 32'd3);
        take();

        beat(32'hC120_0000, 1'b1);
        result("single", 32'hC120_0000, 32'd1);
        take();
        beat(32'h8000_0000, 1'b1);
        result("negzero", 32'h0000_0000, 32'd1);
        take();

        beat(32'h7F80_0000, 1'b0);
        beat(32'hFF80_0000, 1'b1);
        result("inf_minus_inf", 32'h7FFF_FFFF, 32'd2);
        take();
        beat(32'h7FC0_0001, 1'b0);
        beat(32'h3F80_0000, 1'b1);
        result("nan", 32'h7FC0_0001, 32'd2);
        take();

        beat(32'h3FC0_0000, 1'b0);
        beat(32'hBF00_0000, 1'b1);
        result("sub", 32'h3F80_0000, 32'd2);
        take();
        beat(32'h3F80_0000, 1'b0);
        beat(32'h3380_0000, 1'b1);
        result("tie_even", 32'h3F80_0000, 32'd2);
        take();
        beat(32'h3F80_0000, 1'b0);
        beat(32'h3380_0001, 1'b1);
        result("round_up", 32'h3F80_0001, 32'd2);
        take();

        beat(32'h4040_0000, 1'b0);
        beat(32'h3F80_0000, 1'b1);
        in_valid = 1'b1;
        in_data  = 32'h3F80_0000;
        in_last  = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            result("hold", 32'h4080_0000, 32'd2);
        end
        in_valid = 1'b0;
        take();
        beat(32'h4000_0000, 1'b1);
        result("after_hold", 32'h4000_0000, 32'd1);
        take();

        beat(32'h3F80_0000, 1'b0);
        idle(2);
        beat(32'h3F80_0000, 1'b0);
        idle(3);
        check("gap_no_out", 32'(out_valid), 32'd0);
        beat(32'h3F80_0000, 1'b0);
        idle(1);
        beat(32'h3F80_0000, 1'b1);
        result("gaps", 32'h4080_0000, 32'd4);
        take();

        beat(32'h3F80_0000, 1'b0);
        beat(32'h3F80_0000, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check("arst_valid", 32'(out_valid), 32'd0);
        check("arst_data", out_data, 32'd0);
        check("arst_count", 32'(out_count), 32'd0);
        check("arst_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        beat(32'h3F80_0000, 1'b1);
        result("post_rst", 32'h3F80_0000, 32'd1);

        #2 rst_n = 1'b0;
        #1;
        check("done_rst_valid", 32'(out_valid), 32'd0);
        check("done_rst_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int k = 0; k < 4; k++) beat(32'h3F80_0000, 1'b0);
        beat(32'h3F80_0000, 1'b1);
        result("five", 32'h40A0_0000, 32'd5);
        check("sat_valid", 32'(sat_out_valid), 32'd1);
        check("sat_data", sat_out_data, 32'h40A0_0000);
        check("sat_count", 32'(sat_out_count), 32'd3);
        take();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/fp32_accumulator.md
Name: fp32_accumulator

Overview:
- Sequential reduction stage placed directly downstream of the team's combinational fp32_adder.
- Sums a variable-length stream of FP32 partial products into a single FP32 result, using one fp32_adder instance in a feedback loop around an accumulator register.
- Emits one result per packet (a packet ends with in_last) through a valid/ready output, together with the element count.
- Consumed by the PE output/write-back path.

Parameters:
- CNT_W, 16, width of the per-packet element counter; the counter saturates at 2^CNT_W-1.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset; asynchronous, active-low.
- in_valid  input  1  input beat valid.
- in_ready  output  1  accumulator can accept a beat.
- in_data  input  32  FP32 addend.
- in_last  input  1  marks the final beat of a packet.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts the result.
- out_data  output  32  FP32 packet sum.
- out_count  output  CNT_W  number of beats in the packet (saturating).

Behaviour:
- One clock domain.
- Reset is asynchronous and active-low: clk is the clock, rst_n is the reset; polarity and synchronicity are fixed.
- Reset values:
  - state = ACCUM
  - acc = 32'h0000_0000
  - cnt = 0
  - out_valid = 0, out_data = 0, out_count = 0
  - in_ready = 1 (combinational from state)
- Datapath:
  - fp32_adder instance with A = acc and B = in_data; sum = O.
  - The adder's corner-case rules apply unchanged: NaN passthrough, inf-inf gives 32'h7FFF_FFFF, zero operand returns the other operand.
  - Consequence: a packet made only of -0 values yields +0 (32'h0000_0000).
- States:
  - ACCUM:
    - in_ready = 1.
    - On an accepted beat (in_valid & in_ready) with in_last = 0: acc <= sum, cnt <= sat(cnt+1). Stay in ACCUM.
    - On an accepted beat with in_last = 1: out_data <= sum, out_count <= sat(cnt+1), out_valid <= 1, acc <= 0, cnt <= 0. Go to DONE.
  - DONE:
    - in_ready = 0; out_data and out_count are held stable.
    - On out_valid & out_ready: out_valid <= 0. Go to ACCUM.
- Latency:
  - out_valid rises on the clock edge that accepts the last beat, i.e. it is visible the cycle after that beat.
  - Minimum one-bubble turnaround: the next packet's first beat is accepted no earlier than the cycle after the result handshake.
- Throughput: one beat per cycle while in ACCUM.
- Stall: in_valid low in ACCUM leaves acc and cnt unchanged. Any number of idle cycles is allowed mid-packet.
- Backpressure: out_ready low in DONE holds all outputs indefinitely and accepts no input.
- Counter: saturating add; the value stays at 2^CNT_W-1 once reached. The sum itself is unaffected by saturation.
- in_data and in_last are ignored whenever in_valid = 0.
- Reset mid-packet: the partial sum and count are discarded immediately (asynchronously); no output is produced for that packet.
- Reset in DONE: out_valid drops asynchronously and the result is lost.
- No combinational path from out_ready to in_ready. in_ready depends on state only.
- Single-beat packet (in_last on the first beat): out_data = in_data (after the 0 + x rule), out_count = 1.

Test Plan:
- Sum of three beats: 3F80_0000, 4000_0000, 4040_0000 (last) -> out_data = 40C0_0000, out_count = 3, out_valid one cycle after the last beat.
- Single beat C120_0000 with in_last -> out_data = C120_0000, out_count = 1. Single beat 8000_0000 -> out_data = 0000_0000.
- Special values:
  - Beats 7F80_0000, FF80_0000 (last) -> out_data = 7FFF_FFFF.
  - Beats 7FC0_0001, 3F80_0000 (last) -> out_data = 7FC0_0001 (NaN propagates).
- Backpressure: hold out_ready = 0 for 10 cycles after the result -> out_data and out_count are stable and in_ready = 0 throughout. Raise out_ready -> handshake completes, in_ready = 1 next cycle, and the next packet 4000_0000 (last) yields 4000_0000 (accumulator was cleared).
- Gaps and reset:
  - Insert in_valid = 0 gaps inside the packet 3F80_0000 x 4 -> 4080_0000, count 4.
  - Assert rst_n = 0 after 2 beats of a packet -> outputs return to reset values with no clock edge needed. Then the packet 3F80_0000 (last) gives 3F80_0000, count 1.
- Saturation with CNT_W = 2: send 5 beats of 3F80_0000 -> out_count = 3, out_data = 40A0_0000.
